// File: rtl/rails_pkg.sv
// Shared types and sizing helpers for the rails stream checker.
package rails_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Worst case is alternating departures: one single-train range per pair.
    function automatic int stk_depth(input int max_n);
        return (max_n + 1) / 2;
    endfunction

endpackage

// File: rtl/rails_stream_if.sv
// Stream-side bus of the rails checker: qualified input words and verdict outputs.
interface rails_stream_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic [DW-1:0] data;
    logic          valid;
    logic          result;
    logic [DW-1:0] fail_idx;
    logic          busy;

    modport master (
        output in_valid, data,
        input  valid, result, fail_idx, busy
    );

    modport slave (
        input  in_valid, data,
        output valid, result, fail_idx, busy
    );
endinterface

// File: rtl/rails_range_stack.sv
// Stack of contiguous [lo,hi] train ranges waiting in the station; one op per cycle.
module rails_range_stack
    import rails_pkg::*;
#(
    parameter int DW    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          mod_i,
    input  logic [DW-1:0] push_lo_i,
    input  logic [DW-1:0] push_hi_i,
    input  logic [DW-1:0] mod_hi_i,
    output logic          empty_o,
    output logic [DW-1:0] top_lo_o,
    output logic [DW-1:0] top_hi_o
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
    } range_t;

    range_t         mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  top_idx;

    assign wr_idx  = AW'(sp_q);
    assign top_idx = AW'(sp_q - SPW'(1));

    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = '0;
        end else if (push_i) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_i) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Range contents need no reset: an entry is only read below the stack pointer.
    always_ff @(posedge clk) begin
        if (!clr_i) begin
            if (push_i) begin
                mem_q[wr_idx] <= '{lo: push_lo_i, hi: push_hi_i};
            end else if (mod_i) begin
                mem_q[top_idx].hi <= mod_hi_i;
            end
        end
    end

    assign empty_o  = (sp_q == '0);
    assign top_lo_o = mem_q[top_idx].lo;
    assign top_hi_o = mem_q[top_idx].hi;

endmodule

// File: rtl/rails_stream.sv
// Streaming LIFO-station feasibility checker: n, then n departures, one verdict pulse per sequence.
module rails_stream
    import rails_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    rails_stream_if.slave bus
);
    localparam int MAX_N     = (1 << DW) - 1;
    localparam int STK_DEPTH = stk_depth(MAX_N);

    state_e        state_q, state_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] pos_q, pos_d;
    logic [DW:0]   next_q, next_d;
    logic          fail_q, fail_d;
    logic [DW-1:0] fidx_q, fidx_d;
    logic          valid_q, valid_d;
    logic          result_q, result_d;
    logic [DW-1:0] fout_q, fout_d;

    logic          stk_clr, stk_push, stk_pop, stk_mod;
    logic [DW-1:0] push_lo, push_hi, mod_hi;
    logic          stk_empty;
    logic [DW-1:0] top_lo, top_hi;

    logic [DW-1:0] t;
    logic [DW:0]   t_ext;
    logic [DW-1:0] pos_nx;

    assign t      = bus.data;
    assign t_ext  = {1'b0, t};
    assign pos_nx = pos_q + DW'(1);

    rails_range_stack #(
        .DW    (DW),
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (stk_clr),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .mod_i     (stk_mod),
        .push_lo_i (push_lo),
        .push_hi_i (push_hi),
        .mod_hi_i  (mod_hi),
        .empty_o   (stk_empty),
        .top_lo_o  (top_lo),
        .top_hi_o  (top_hi)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        pos_d    = pos_q;
        next_d   = next_q;
        fail_d   = fail_q;
        fidx_d   = fidx_q;
        valid_d  = 1'b0;
        result_d = result_q;
        fout_d   = fout_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_mod  = 1'b0;
        push_lo  = next_q[DW-1:0];
        push_hi  = t - DW'(1);
        mod_hi   = t - DW'(1);

        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    n_d     = t;
                    pos_d   = '0;
                    next_d  = (DW+1)'(1);
                    fail_d  = 1'b0;
                    fidx_d  = '0;
                    stk_clr = 1'b1;
                    if (t == '0) begin
                        valid_d  = 1'b1;
                        result_d = 1'b1;
                        fout_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    pos_d = pos_nx;
                    if (!fail_q) begin
                        if (t == '0 || t > n_q) begin
                            fail_d = 1'b1;
                            fidx_d = pos_nx;
                        end else if (t_ext >= next_q) begin
                            // Trains next_in..t-1 enter the station as one range; t leaves directly.
                            stk_push = (t_ext > next_q);
                            next_d   = t_ext + (DW+1)'(1);
                        end else if (!stk_empty && top_hi == t) begin
                            stk_pop = (top_lo == t);
                            stk_mod = (top_lo != t);
                        end else begin
                            fail_d = 1'b1;
                            fidx_d = pos_nx;
                        end
                    end
                    if (pos_nx == n_q) begin
                        state_d  = IDLE;
                        valid_d  = 1'b1;
                        result_d = !fail_d;
                        fout_d   = fail_d ? fidx_d : '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            pos_q    <= '0;
            next_q   <= (DW+1)'(1);
            fail_q   <= 1'b0;
            fidx_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= 1'b0;
            fout_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            pos_q    <= pos_d;
            next_q   <= next_d;
            fail_q   <= fail_d;
            fidx_q   <= fidx_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            fout_q   <= fout_d;
        end
    end

    assign bus.valid    = valid_q;
    assign bus.result   = result_q;
    assign bus.fail_idx = fout_q;
    assign bus.busy     = (state_q == RUN);

endmodule

// File: tb/tb_rails_stream.sv
// Randomised bench for rails_stream at DW=4 and DW=8 against a train-by-train station model.
module tb_rails_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rails_stream_if #(.DW(4)) bus4 ();
    rails_stream_if #(.DW(8)) bus8 ();

    rails_stream #(.DW(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    rails_stream #(.DW(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

    typedef struct {
        int due;
        int res;
        int fidx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   exp_busy[2];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input int s, input logic v, input int d);
        if (s == 0) begin
            bus4.in_valid = v;
            bus4.data     = 4'(d);
        end else begin
            bus8.in_valid = v;
            bus8.data     = 8'(d);
        end
    endtask

    // Reference: every train individually, pushed in arrival order; departure must be the top.
    task automatic model(input int n, input int seq[$], output int r, output int f);
        int stk[$];
        int nxt;
        nxt = 1;
        r = 1;
        f = 0;
        for (int i = 0; i < n; i++) begin
            if (seq[i] < 1 || seq[i] > n) begin
                r = 0;
                f = i + 1;
                return;
            end
            while (nxt <= seq[i]) begin
                stk.push_back(nxt);
                nxt++;
            end
            if (stk.size() > 0 && stk[$] == seq[i]) begin
                void'(stk.pop_back());
            end else begin
                r = 0;
                f = i + 1;
                return;
            end
        end
    endtask

    task automatic beat(input int s, input int d, input int gap);
        while (gap > 0 && $urandom_range(99) < gap) begin
            drive(s, 1'b0, int'($urandom));
            @(posedge clk);
            #1;
        end
        drive(s, 1'b1, d);
        @(posedge clk);
        #1;
        drive(s, 1'b0, int'($urandom));
    endtask

    task automatic push_exp(input int s, input int r, input int f);
        exp_t e;
        e.due  = cyc;
        e.res  = r;
        e.fidx = f;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic send(input int s, input int n, input int seq[$], input int gap,
                        input int lit_r = -1, input int lit_f = -1);
        int r, f;
        model(n, seq, r, f);
        if (lit_r >= 0) begin
            vectors++;
            if (r != lit_r || f != lit_f) begin
                errors++;
                $display("FAIL model_pin n=%0d: got result=%0d fidx=%0d, want result=%0d fidx=%0d",
                         n, r, f, lit_r, lit_f);
            end
        end
        beat(s, n, gap);
        if (n == 0) begin
            push_exp(s, 1, 0);
        end else begin
            exp_busy[s] = 1;
            for (int i = 0; i < n; i++) beat(s, seq[i], gap);
            exp_busy[s] = 0;
            push_exp(s, r, f);
        end
    endtask

    task automatic chk(input int s, input logic v, input logic r, input int f, input logic b);
        exp_t head;
        bit   has;
        has = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) head = (s == 0) ? q0[0] : q1[0];
        vectors++;
        if (b !== 1'(exp_busy[s])) begin
            errors++;
            $display("FAIL busy dut%0d cyc=%0d: got %b, want %0d", s, cyc, b, exp_busy[s]);
        end
        if (has && head.due < cyc) begin
            vectors++;
            errors++;
            $display("FAIL verdict_missing dut%0d: due cyc=%0d, still absent at cyc=%0d", s, head.due, cyc);
            if (s == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            has = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (has) head = (s == 0) ? q0[0] : q1[0];
        end
        if (v === 1'b1) begin
            vectors++;
            if (!has || head.due != cyc) begin
                errors++;
                $display("FAIL unexpected_valid dut%0d cyc=%0d: got valid=1, want 0", s, cyc);
            end else begin
                if (r !== 1'(head.res) || f != head.fidx) begin
                    errors++;
                    $display("FAIL verdict dut%0d cyc=%0d: got result=%b fail_idx=%0d, want result=%0d fail_idx=%0d",
                             s, cyc, r, f, head.res, head.fidx);
                end
                if (s == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else if (v !== 1'b0) begin
            vectors++;
            errors++;
            $display("FAIL valid_x dut%0d cyc=%0d: got %b, want 0/1", s, cyc, v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk(0, bus4.valid, bus4.result, int'(bus4.fail_idx), bus4.busy);
            chk(1, bus8.valid, bus8.result, int'(bus8.fail_idx), bus8.busy);
        end
    end

    task automatic lit_reset_chk(input int s, input logic v, input logic r, input int f, input logic b);
        vectors++;
        if (v !== 1'b0 || r !== 1'b0 || f != 0 || b !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got valid=%b result=%b fail_idx=%0d busy=%b, want all 0",
                     s, v, r, f, b);
        end
    endtask

    task automatic gen_ok(input int n, output int seq[$]);
        int stk[$];
        int nxt;
        seq = {};
        nxt = 1;
        while (seq.size() < n) begin
            if (stk.size() > 0 && (nxt > n || $urandom_range(1) == 1)) begin
                seq.push_back(stk.pop_back());
            end else begin
                stk.push_back(nxt);
                nxt++;
            end
        end
    endtask

    task automatic gen_perm(input int n, output int seq[$]);
        int tmp, j;
        seq = {};
        for (int i = 1; i <= n; i++) seq.push_back(i);
        for (int i = n - 1; i > 0; i--) begin
            j = int'($urandom_range(i));
            tmp = seq[i];
            seq[i] = seq[j];
            seq[j] = tmp;
        end
    endtask

    task automatic random_block(input int s, input int iters, input int nmax);
        int seq[$];
        int n, k;
        for (int it = 0; it < iters; it++) begin
            n = int'($urandom_range(nmax, 1));
            k = it % 3;
            if (k == 0) begin
                gen_ok(n, seq);
            end else if (k == 1) begin
                gen_perm(n, seq);
            end else begin
                gen_ok(n, seq);
                seq[$urandom_range(n - 1)] = int'($urandom_range(n + 1));
            end
            send(s, n, seq, (it % 2 == 0) ? 30 : 0);
        end
    endtask

    initial begin
        int seq[$];
        reset = 1'b1;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        exp_busy[0] = 0;
        exp_busy[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        lit_reset_chk(0, bus4.valid, bus4.result, int'(bus4.fail_idx), bus4.busy);
        lit_reset_chk(1, bus8.valid, bus8.result, int'(bus8.fail_idx), bus8.busy);
        reset = 1'b0;
        chk_on = 1'b1;

        // DW=4 directed sequences, back-to-back
        send(0, 5, '{1, 2, 3, 4, 5}, 0, 1, 0);
        send(0, 5, '{5, 4, 3, 2, 1}, 0, 1, 0);
        send(0, 5, '{5, 4, 1, 2, 3}, 0, 0, 3);
        send(0, 1, '{1}, 0, 1, 0);
        send(0, 3, '{1, 4, 2}, 0, 0, 2);
        send(0, 3, '{2, 2, 1}, 0, 0, 2);
        seq = {};
        send(0, 0, seq, 0, 1, 0);
        send(0, 0, seq, 0, 1, 0);
        send(0, 7, '{3, 2, 1, 7, 6, 5, 4}, 30, 1, 0);
        send(0, 4, '{0, 1, 2, 3}, 0, 0, 1);
        send(0, 15, '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1}, 0, 1, 0);

        // Reset abandons a sequence after 3 of 6 elements
        beat(0, 6, 0);
        exp_busy[0] = 1;
        beat(0, 1, 0);
        beat(0, 2, 0);
        beat(0, 3, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_busy[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 2, '{2, 1}, 0, 1, 0);

        random_block(0, 30, 15);

        // DW=8 directed sequences
        seq = {};
        for (int i = 255; i >= 1; i--) seq.push_back(i);
        send(1, 255, seq, 0, 1, 0);
        seq = {};
        for (int i = 1; i <= 127; i++) begin
            seq.push_back(2 * i);
            seq.push_back(2 * i - 1);
        end
        seq.push_back(255);
        send(1, 255, seq, 0, 1, 0);
        seq = {};
        for (int i = 1; i <= 127; i++) seq.push_back(2 * i);
        seq.push_back(255);
        for (int i = 127; i >= 1; i--) seq.push_back(2 * i - 1);
        send(1, 255, seq, 10, 1, 0);
        seq[254] = 3;
        send(1, 255, seq, 0, 0, 255);

        random_block(1, 45, 60);

        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_verdicts: got %0d/%0d outstanding, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
